// File: rtl/pwm_fade_pkg.sv
// Shared types and default widths for the PWM duty-cycle fade controller.
package pwm_fade_pkg;

    localparam int DUTY_W_DEFAULT = 8;
    localparam int DIV_W_DEFAULT  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } fade_state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } step_dir_t;

endpackage

// File: rtl/fade_tick_gen.sv
// Step-interval divider: tick is high whenever the counter equals tick_div,
// so a step lands every tick_div+1 running clocks.
module fade_tick_gen
    import pwm_fade_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] tick_div,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt;

    // Combinational compare so a live change of tick_div applies at once.
    assign tick = (div_cnt == tick_div);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div_cnt <= '0;
        end else if (run) begin
            if (tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_fade_controller.sv
// Ramps duty_out toward a loaded target in step_size increments, one step
// every tick_div+1 enabled clocks, with one-cycle done on arrival.
module pwm_fade_controller
    import pwm_fade_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEFAULT,
    parameter int DIV_W  = DIV_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              load,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic [DUTY_W-1:0] step_size,
    input  logic [DIV_W-1:0]  tick_div,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              done
);

    fade_state_t       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    step_dir_t         dir;
    logic              run;
    logic              tick;

    // Saturating step in DUTY_W+1 bits: never overshoots, wraps or underflows.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W-1:0] step,
        input step_dir_t         d
    );
        logic [DUTY_W:0] wide;
        logic [DUTY_W-1:0] res;
        res = tgt;
        if (d == UP) begin
            wide = {1'b0, cur} + {1'b0, step};
            if (wide < {1'b0, tgt}) begin
                res = wide[DUTY_W-1:0];
            end
        end else begin
            wide = {1'b0, tgt} + {1'b0, step};
            if ({1'b0, cur} > wide) begin
                res = cur - step;
            end
        end
        return res;
    endfunction

    assign run = enable && (state_q == RAMP);

    fade_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (load),
        .run      (run),
        .tick_div (tick_div),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            target_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        done_d   = 1'b0;
        dir      = (duty_q < target_q) ? UP : DOWN;

        // A load always takes priority over a coincident step compare.
        if (load) begin
            target_d = target_duty;
            if (target_duty == duty_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (step_size == '0) begin
                duty_d  = target_duty;
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = RAMP;
            end
        end else if (run && tick) begin
            duty_d = step_toward(duty_q, target_q, step_size, dir);
            if (duty_d == target_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        busy_d = (state_d == RAMP);
    end

    assign duty_out = duty_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Directed bench for pwm_fade_controller: ramp timing, clamping, freeze,
// retarget, immediate jumps and reset abort.
module tb_pwm_fade_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [7:0]  target_duty;
    logic [7:0]  step_size;
    logic [15:0] tick_div;
    logic [7:0]  duty_out;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    pwm_fade_controller #(
        .DUTY_W (8),
        .DIV_W  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .load        (load),
        .target_duty (target_duty),
        .step_size   (step_size),
        .tick_div    (tick_div),
        .duty_out    (duty_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle load strobe; returns just after the capturing edge.
    task automatic do_load(input logic [7:0] tgt, input logic [7:0] stp, input logic [15:0] td);
        target_duty = tgt;
        step_size   = stp;
        tick_div    = td;
        load        = 1'b1;
        cyc();
        load        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        checks++;
        if (duty_out !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: duty=%0d busy=%b done=%b expected 0/0/0", duty_out, busy, done);
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (duty_out !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL idle_cycle%0d: duty=%0d busy=%b done=%b expected 0/0/0", i, duty_out, busy, done);
            end
        end
    endtask

    task automatic test_ramp_up();
        logic [7:0] exp_duty [5];
        exp_duty = '{8'd0, 8'd3, 8'd6, 8'd9, 8'd10};
        do_load(8'd10, 8'd3, 16'd0);
        checks++;
        if (duty_out !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL up_load_edge: duty=%0d busy=%b done=%b expected 0/1/0", duty_out, busy, done);
        end
        for (int i = 1; i <= 4; i++) begin
            cyc();
            checks++;
            if (duty_out !== exp_duty[i] || busy !== (i < 4) || done !== (i == 4)) begin
                failures++;
                $display("FAIL up_step%0d: duty=%0d busy=%b done=%b expected %0d/%b/%b",
                         i, duty_out, busy, done, exp_duty[i], (i < 4), (i == 4));
            end
        end
        cyc();
        checks++;
        if (done !== 1'b0 || duty_out !== 8'd10) begin
            failures++;
            $display("FAIL up_done_once: duty=%0d done=%b expected 10/0", duty_out, done);
        end
    endtask

    task automatic test_ramp_down();
        logic [7:0] exp_d;
        do_load(8'd200, 8'd0, 16'd0);
        cyc();
        checks++;
        if (duty_out !== 8'd200) begin
            failures++;
            $display("FAIL down_preset: duty=%0d expected 200", duty_out);
        end
        do_load(8'd0, 8'd64, 16'd3);
        for (int j = 1; j <= 16; j++) begin
            cyc();
            if (j < 4)       exp_d = 8'd200;
            else if (j < 8)  exp_d = 8'd136;
            else if (j < 12) exp_d = 8'd72;
            else if (j < 16) exp_d = 8'd8;
            else             exp_d = 8'd0;
            checks++;
            if (duty_out !== exp_d || busy !== (j < 16) || done !== (j == 16)) begin
                failures++;
                $display("FAIL down_edge%0d: duty=%0d busy=%b done=%b expected %0d/%b/%b",
                         j, duty_out, busy, done, exp_d, (j < 16), (j == 16));
            end
        end
        cyc();
    endtask

    task automatic test_freeze_clamp();
        logic [7:0] exp_d;
        do_load(8'd255, 8'd16, 16'd1);
        for (int j = 1; j <= 4; j++) cyc();
        checks++;
        if (duty_out !== 8'd32 || busy !== 1'b1) begin
            failures++;
            $display("FAIL freeze_pre: duty=%0d busy=%b expected 32/1", duty_out, busy);
        end
        enable = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cyc();
            checks++;
            if (duty_out !== 8'd32 || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL freeze_hold%0d: duty=%0d busy=%b done=%b expected 32/1/0", j, duty_out, busy, done);
            end
        end
        enable = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            cyc();
            exp_d = (c < 28) ? 8'(32 + 16 * (c / 2)) : 8'd255;
            checks++;
            if (duty_out !== exp_d || done !== (c == 28)) begin
                failures++;
                $display("FAIL resume_edge%0d: duty=%0d done=%b expected %0d/%b", c, duty_out, done, exp_d, (c == 28));
            end
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || duty_out !== 8'd255) begin
            failures++;
            $display("FAIL clamp_final: duty=%0d busy=%b expected 255/0", duty_out, busy);
        end
    endtask

    task automatic test_retarget();
        logic [7:0] exp_duty [4];
        int done_count;
        exp_duty   = '{8'd48, 8'd32, 8'd32, 8'd20};
        done_count = 0;
        do_load(8'd0, 8'd0, 16'd0);
        cyc();
        do_load(8'd200, 8'd16, 16'd1);
        for (int j = 1; j <= 7; j++) begin
            cyc();
            if (done) done_count++;
        end
        checks++;
        if (duty_out !== 8'd48) begin
            failures++;
            $display("FAIL retarget_pre: duty=%0d expected 48", duty_out);
        end
        do_load(8'd20, 8'd16, 16'd1);
        if (done) done_count++;
        checks++;
        if (duty_out !== 8'd48 || busy !== 1'b1) begin
            failures++;
            $display("FAIL retarget_load_wins: duty=%0d busy=%b expected 48/1", duty_out, busy);
        end
        for (int j = 0; j < 4; j++) begin
            cyc();
            if (done) done_count++;
            checks++;
            if (duty_out !== exp_duty[j]) begin
                failures++;
                $display("FAIL retarget_edge%0d: duty=%0d expected %0d", j + 1, duty_out, exp_duty[j]);
            end
        end
        cyc();
        if (done) done_count++;
        checks++;
        if (done_count != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL retarget_done_count: count=%0d busy=%b expected 1/0", done_count, busy);
        end
    endtask

    task automatic test_jump_and_abort();
        do_load(8'd77, 8'd0, 16'd0);
        checks++;
        if (duty_out !== 8'd77 || busy !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL jump: duty=%0d busy=%b done=%b expected 77/0/1", duty_out, busy, done);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL jump_after: done=%b busy=%b expected 0/0", done, busy);
        end
        do_load(8'd77, 8'd5, 16'd2);
        checks++;
        if (duty_out !== 8'd77 || busy !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL equal_target: duty=%0d busy=%b done=%b expected 77/0/1", duty_out, busy, done);
        end
        cyc();
        do_load(8'd200, 8'd1, 16'd0);
        cyc();
        cyc();
        checks++;
        if (duty_out !== 8'd79 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre: duty=%0d busy=%b expected 79/1", duty_out, busy);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (duty_out !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset: duty=%0d busy=%b done=%b expected 0/0/0", duty_out, busy, done);
        end
        cyc();
        checks++;
        if (duty_out !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_after: duty=%0d busy=%b done=%b expected 0/0/0", duty_out, busy, done);
        end
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b1;
        load        = 1'b0;
        target_duty = 8'd0;
        step_size   = 8'd0;
        tick_div    = 16'd0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_freeze_clamp();
        test_retarget();
        test_jump_and_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
